alu16_op_sequencer: RTL and testbench
=====================================

Name: alu16_op_sequencer

Overview:
- Multi-cycle controller that sequences the 16-bit ALU and its 4-way output mux (Result / Less / ShiftL / ShiftR).
- Accepts one operation at a time over a valid/ready request channel and drives the ALU operand and select lines.
- Iterates the single-bit ALU shifters to perform shifts by 0..15 bits, and returns the result over a valid/ready response channel.
- Sits between the CPU control unit (or register-file read stage) and the ALU.

Parameters:
- WIDTH, 16, datapath width of operands, ALU lines and result.
- SHW, 4, shift-amount width; maximum shift is 2^SHW-1.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-low reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  sequencer can accept a request.
- Opcode  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 SLL, 110 SRL, 111 illegal.
- OpA  input  WIDTH  operand A; also the shift source.
- OpB  input  WIDTH  operand B; ignored for shifts.
- ShAmt  input  SHW  shift count, used only by SLL/SRL.
- AluA  output  WIDTH  ALU operand A (registered).
- AluB  output  WIDTH  ALU operand B (registered).
- AluS  output  3  ALU output-mux select: 000 Result, 001 Less, 110 ShiftL (1 bit), 111 ShiftR (1 bit).
- AluOp  output  2  Result sub-function: 00 AND, 01 OR, 10 ADD, 11 SUB.
- AluY  input  WIDTH  ALU output (post-mux), combinational from AluA/AluB/AluS/AluOp.
- RespValid  output  1  result available.
- RespReady  input  1  consumer accepts the result.
- RespData  output  WIDTH  result.
- RespErr  output  1  illegal opcode flag, qualified by RespValid.
- Busy  output  1  high in every state except IDLE.

Behaviour:
Reset
- Reset is sampled on the rising Clock edge while low.
- Forces IDLE, from any state, mid-operation included; any in-flight operation is discarded with no response.
- Reset values: ReqReady=1, RespValid=0, RespErr=0, Busy=0, RespData=0, AluA=0, AluB=0, AluS=000, AluOp=00, shift counter=0.

States
- IDLE, EXEC, SHIFT, DONE.
- ReqReady = (state==IDLE). One operation in flight; no request/response overlap.

IDLE
- Transition fires on ReqValid&&ReqReady. Latch AluA<=OpA, AluB<=OpB, counter<=ShAmt.
- AND/OR/ADD/SUB: AluS=000, AluOp per opcode -> EXEC.
- SLT: AluS=001, AluOp=11 -> EXEC. AluY is 1 if signed A<B, else 0; produced by the ALU.
- SLL: AluS=110; SRL: AluS=111.
  - ShAmt!=0 -> SHIFT.
  - ShAmt==0 -> DONE with RespData=OpA; the ALU is not used.
- Opcode 111 -> DONE with RespErr=1, RespData=0.

EXEC (one cycle)
- RespData<=AluY -> DONE.

SHIFT (one cycle per bit)
- Each cycle: AluA<=AluY, RespData<=AluY, counter<=counter-1.
- When counter==1 in this cycle -> DONE.
- Shift-in is 0 for both directions (SRL is logical). Bits shifted out are lost.
- A count of 15 yields only the surviving bit.

DONE
- RespValid=1; RespData and RespErr are held stable until RespReady.
- On RespValid&&RespReady -> IDLE. The next request is accepted no earlier than the following cycle.
- On leaving DONE: AluS=000, AluOp=00, RespErr=0. RespData retains its last value.

Latency, request accept edge to first RespValid cycle
- ALU ops: 2 cycles.
- Shift by n (n>=1): n+1 cycles.
- Shift by 0 and illegal opcode: 1 cycle.

Arithmetic
- Width is WIDTH bits throughout; ADD/SUB wrap modulo 2^WIDTH; no carry or overflow outputs.

Handshake rules
- ReqValid while Busy is ignored and does not need to be held stable.
- RespReady while RespValid=0 has no effect.
- AluA/AluB/AluS/AluOp change only on Clock edges.

Test Plan:
1. Reset low 2 cycles mid-SHIFT (SLL, ShAmt=9, cycle 3) -> next cycle: IDLE, ReqReady=1, RespValid=0, AluS=000; no response is ever produced.
2. ADD OpA=16'hFFFF, OpB=16'h0002, RespReady=1 -> RespValid 2 cycles after accept, RespData=16'h0001, RespErr=0; SUB 16'h0003-16'h0005 -> 16'hFFFE.
3. SLL OpA=16'h0001, ShAmt=15 -> AluS=110 for 15 cycles, RespValid at cycle 16, RespData=16'h8000; SRL OpA=16'h8000, ShAmt=4 -> 16'h0800 at cycle 5.
4. SLL/SRL with ShAmt=0, OpA=16'h1234 -> RespValid 1 cycle after accept, RespData=16'h1234, AluY never sampled.
5. Opcode=111 -> RespValid after 1 cycle, RespErr=1, RespData=0; SLT OpA=16'hFFFF (-1), OpB=16'h0001 -> RespData=16'h0001.
6. Back-pressure: OR 16'h00F0|16'h0F00 with RespReady=0 for 5 cycles -> RespValid and RespData=16'h0FF0 held, ReqReady=0; a new ReqValid in that window is ignored; RespReady=1 -> IDLE next cycle.

Source files
------------

// File: rtl/alu16_op_sequencer.sv
// Multi-cycle controller that sequences a 16-bit ALU: single-cycle ALU ops,
// iterated 1-bit shifts, and illegal-opcode reporting over valid/ready channels.
module alu16_op_sequencer #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [2:0]       Opcode,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [SHW-1:0]   ShAmt,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic [2:0]       AluS,
    output logic [1:0]       AluOp,
    input  logic [WIDTH-1:0] AluY,
    output logic             RespValid,
    input  logic             RespReady,
    output logic [WIDTH-1:0] RespData,
    output logic             RespErr,
    output logic             Busy,
    output logic [1:0]       DbgState
);

    // Handshakes: a request transfers on a rising edge where ReqValid && ReqReady;
    // a response transfers on a rising edge where RespValid && RespReady. Only one
    // operation is in flight, so ReqReady is low for the whole request-to-response span.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] SEL_RESULT = 3'b000;
    localparam logic [2:0] SEL_LESS   = 3'b001;
    localparam logic [2:0] SEL_SHL    = 3'b110;
    localparam logic [2:0] SEL_SHR    = 3'b111;

    state_t         state;
    logic [SHW-1:0] count;

    assign ReqReady  = (state == IDLE);
    assign RespValid = (state == DONE);
    assign Busy      = (state != IDLE);
    assign DbgState  = state;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= IDLE;
            count    <= '0;
            AluA     <= '0;
            AluB     <= '0;
            AluS     <= SEL_RESULT;
            AluOp    <= 2'b00;
            RespData <= '0;
            RespErr  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        AluA  <= OpA;
                        AluB  <= OpB;
                        count <= ShAmt;
                        case (Opcode)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                AluS  <= SEL_RESULT;
                                AluOp <= Opcode[1:0];
                                state <= EXEC;
                            end
                            3'b100: begin
                                AluS  <= SEL_LESS;
                                AluOp <= 2'b11;
                                state <= EXEC;
                            end
                            3'b101, 3'b110: begin
                                AluS <= (Opcode == 3'b101) ? SEL_SHL : SEL_SHR;
                                if (ShAmt != '0) begin
                                    state <= SHIFT;
                                end else begin
                                    // Zero-length shift bypasses the ALU entirely.
                                    RespData <= OpA;
                                    state    <= DONE;
                                end
                            end
                            default: begin
                                RespErr  <= 1'b1;
                                RespData <= '0;
                                state    <= DONE;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    RespData <= AluY;
                    state    <= DONE;
                end
                SHIFT: begin
                    // Feed the 1-bit shifter output back into operand A each cycle.
                    AluA     <= AluY;
                    RespData <= AluY;
                    count    <= count - 1'b1;
                    if (count == SHW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (RespReady) begin
                        AluS    <= SEL_RESULT;
                        AluOp   <= 2'b00;
                        RespErr <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_op_sequencer.sv
// Self-checking bench for alu16_op_sequencer: behavioural ALU, directed
// scenarios and randomized operations checked against an arithmetic reference model.
module tb_alu16_op_sequencer;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic             Clock;
    logic             Reset;
    logic             ReqValid;
    logic             ReqReady;
    logic [2:0]       Opcode;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic [SHW-1:0]   ShAmt;
    logic [WIDTH-1:0] AluA;
    logic [WIDTH-1:0] AluB;
    logic [2:0]       AluS;
    logic [1:0]       AluOp;
    logic [WIDTH-1:0] AluY;
    logic             RespValid;
    logic             RespReady;
    logic [WIDTH-1:0] RespData;
    logic             RespErr;
    logic             Busy;
    logic [1:0]       DbgState;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             exp_err_q[$];
    int               exp_lat_q[$];

    alu16_op_sequencer #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .Opcode(Opcode), .OpA(OpA), .OpB(OpB), .ShAmt(ShAmt),
        .AluA(AluA), .AluB(AluB), .AluS(AluS), .AluOp(AluOp), .AluY(AluY),
        .RespValid(RespValid), .RespReady(RespReady),
        .RespData(RespData), .RespErr(RespErr),
        .Busy(Busy), .DbgState(DbgState)
    );

    // Clock / reset block
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural ALU with its 4-way output mux
    always_comb begin
        AluY = '0;
        case (AluS)
            3'b000: begin
                case (AluOp)
                    2'b00: AluY = AluA & AluB;
                    2'b01: AluY = AluA | AluB;
                    2'b10: AluY = AluA + AluB;
                    default: AluY = AluA - AluB;
                endcase
            end
            3'b001:  AluY = ($signed(AluA) < $signed(AluB)) ? 16'd1 : 16'd0;
            3'b110:  AluY = AluA << 1;
            3'b111:  AluY = AluA >> 1;
            default: AluY = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the operation's value computed directly from its definition
    function automatic logic [WIDTH-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b, input int sh);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return WIDTH'((32'(a) + 32'(b)) % 65536);
            3'd3: return WIDTH'((32'(a) + 65536 - 32'(b)) % 65536);
            3'd4: return (int'($signed(a)) < int'($signed(b))) ? 16'd1 : 16'd0;
            3'd5: return WIDTH'((32'(a) * (32'd1 << sh)) % 65536);
            3'd6: return WIDTH'(32'(a) / (32'd1 << sh));
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input int sh);
        if (op == 3'd7) return 1;
        if (op == 3'd5 || op == 3'd6) return (sh == 0) ? 1 : sh + 1;
        return 2;
    endfunction

    task automatic randomize_inputs();
        Opcode = 3'($urandom_range(0, 7));
        OpA    = 16'($urandom);
        OpB    = 16'($urandom);
        ShAmt  = 4'($urandom_range(0, 15));
    endtask

    // Driver: issue one request, follow it to the response, apply back-pressure
    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int sh, input int hold);
        int               cycles;
        logic [WIDTH-1:0] exp_d;
        logic             exp_e;
        int               exp_l;
        logic [WIDTH-1:0] held;
        @(negedge Clock);
        check("req_ready_idle", 32'(ReqReady), 32'd1);
        Opcode    = op;
        OpA       = a;
        OpB       = b;
        ShAmt     = 4'(sh);
        ReqValid  = 1'b1;
        RespReady = (hold == 0);
        exp_q.push_back(model(op, a, b, sh));
        exp_err_q.push_back(op == 3'd7);
        exp_lat_q.push_back(model_lat(op, sh));
        @(negedge Clock);
        ReqValid = 1'b0;
        randomize_inputs();
        check("alu_a_latched", 32'(AluA), 32'(a));
        check("busy_after_accept", 32'(Busy), 32'd1);
        if ((op == 3'd5 || op == 3'd6) && sh != 0)
            check("shift_sel", 32'(AluS), (op == 3'd5) ? 32'd6 : 32'd7);
        cycles = 1;
        while (!RespValid && cycles < 40) begin
            @(negedge Clock);
            cycles++;
        end
        exp_d = exp_q.pop_front();
        exp_e = exp_err_q.pop_front();
        exp_l = exp_lat_q.pop_front();
        check("latency", 32'(cycles), 32'(exp_l));
        check("resp_data", 32'(RespData), 32'(exp_d));
        check("resp_err", 32'(RespErr), 32'(exp_e));
        held = RespData;
        for (int i = 0; i < hold; i++) begin
            ReqValid = 1'b1;
            randomize_inputs();
            @(negedge Clock);
            check("hold_valid", 32'(RespValid), 32'd1);
            check("hold_data", 32'(RespData), 32'(held));
            check("hold_req_ready", 32'(ReqReady), 32'd0);
        end
        ReqValid  = 1'b0;
        RespReady = 1'b1;
        @(negedge Clock);
        check("idle_after_resp", 32'(Busy), 32'd0);
        check("idle_resp_valid", 32'(RespValid), 32'd0);
        check("idle_alu_s", 32'(AluS), 32'd0);
        check("idle_resp_err", 32'(RespErr), 32'd0);
        RespReady = 1'b0;
    endtask

    initial begin
        bit saw_resp;
        Reset     = 1'b0;
        ReqValid  = 1'b0;
        RespReady = 1'b0;
        Opcode    = '0;
        OpA       = '0;
        OpB       = '0;
        ShAmt     = '0;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("rst_req_ready", 32'(ReqReady), 32'd1);
        check("rst_resp_valid", 32'(RespValid), 32'd0);
        check("rst_resp_err", 32'(RespErr), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_resp_data", 32'(RespData), 32'd0);
        check("rst_alu_a", 32'(AluA), 32'd0);
        check("rst_alu_b", 32'(AluB), 32'd0);
        check("rst_alu_s", 32'(AluS), 32'd0);
        check("rst_alu_op", 32'(AluOp), 32'd0);

        // Reset mid-shift discards the operation
        Opcode = 3'd5; OpA = 16'h0001; OpB = 16'h0000; ShAmt = 4'd9; ReqValid = 1'b1;
        @(negedge Clock);
        ReqValid = 1'b0;
        RespReady = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        check("midrst_req_ready", 32'(ReqReady), 32'd1);
        check("midrst_resp_valid", 32'(RespValid), 32'd0);
        check("midrst_alu_s", 32'(AluS), 32'd0);
        saw_resp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (RespValid) saw_resp = 1'b1;
        end
        check("midrst_no_resp", 32'(saw_resp), 32'd0);
        RespReady = 1'b0;

        // Directed scenarios
        send(3'd2, 16'hFFFF, 16'h0002, 0, 0);
        send(3'd3, 16'h0003, 16'h0005, 0, 0);
        send(3'd5, 16'h0001, 16'h0000, 15, 0);
        send(3'd6, 16'h8000, 16'h0000, 4, 0);
        send(3'd5, 16'h1234, 16'h0000, 0, 0);
        send(3'd6, 16'h1234, 16'h0000, 0, 0);
        send(3'd7, 16'hABCD, 16'h1111, 0, 1);
        send(3'd4, 16'hFFFF, 16'h0001, 0, 0);
        send(3'd4, 16'h0001, 16'hFFFF, 0, 0);
        send(3'd1, 16'h00F0, 16'h0F00, 0, 5);
        send(3'd0, 16'hF0F0, 16'h3C3C, 0, 0);
        send(3'd6, 16'hFFFF, 16'h0000, 15, 2);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
